// File: rtl/grill_pkg.sv
// Shared grill definitions: per-slot cook state encoding, reused by the
// timer, scoring and display blocks.
package grill_pkg;

   localparam int unsigned SLOT_STATE_W = 2;

   typedef enum logic [SLOT_STATE_W-1:0] {
      IDLE    = 2'd0,
      COOKING = 2'd1,
      DONE    = 2'd2,
      BURNT   = 2'd3
   } slot_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a registered one-cycle tick every CLK_DIV
// clocks and a square-wave beat. Optional hold input under GRILL_TIMER_PAUSE_EN.
module tick_prescaler #(
   parameter int unsigned CLK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic resetn,
`ifdef GRILL_TIMER_PAUSE_EN
   input  logic pause,
`endif
   output logic tick,
   output logic beat
);

   localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             run;
   logic             wrap;

`ifdef GRILL_TIMER_PAUSE_EN
   assign run = ~pause;
`else
   assign run = 1'b1;
`endif

   assign wrap = run && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt  <= '0;
         tick <= 1'b0;
         beat <= 1'b0;
      end else begin
         if (run) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
         end
         tick <= wrap;
         beat <= beat ^ wrap;
      end
   end

endmodule

// File: rtl/grill_timer.sv
// Multi-slot grill cook timer: shared one-second prescaler plus NUM_SLOTS
// independent IDLE/COOKING/DONE/BURNT slots. Optional pause: GRILL_TIMER_PAUSE_EN.
module grill_timer
   import grill_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned CLK_DIV   = 50_000_000,
   parameter int unsigned SEC_W     = 6,
   parameter int unsigned COOK_SECS = 10,
   parameter int unsigned BURN_SECS = 20
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_SLOTS-1:0]          start,
   input  logic [NUM_SLOTS-1:0]          remove,
`ifdef GRILL_TIMER_PAUSE_EN
   input  logic                          pause,
`endif
   output logic                          tick,
   output logic                          beat,
   output logic [2*NUM_SLOTS-1:0]        slot_state,
   output logic [SEC_W*NUM_SLOTS-1:0]    elapsed,
   output logic [NUM_SLOTS-1:0]          done_pulse,
   output logic [NUM_SLOTS-1:0]          burnt_pulse
);

   localparam logic [SEC_W-1:0] SEC_MAX   = '1;
   localparam logic [SEC_W-1:0] COOK_LAST = SEC_W'(COOK_SECS - 1);
   localparam logic [SEC_W-1:0] BURN_LAST = SEC_W'(BURN_SECS - 1);

   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .resetn (resetn),
`ifdef GRILL_TIMER_PAUSE_EN
      .pause  (pause),
`endif
      .tick   (tick),
      .beat   (beat)
   );

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      slot_state_t      state_q, state_d;
      logic [SEC_W-1:0] elap_q, elap_d;
      logic             done_d, burnt_d;
      logic             done_q, burnt_q;

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            state_q <= IDLE;
            elap_q  <= '0;
            done_q  <= 1'b0;
            burnt_q <= 1'b0;
         end else begin
            state_q <= state_d;
            elap_q  <= elap_d;
            done_q  <= done_d;
            burnt_q <= burnt_d;
         end
      end

      // Comparing the pre-increment count against threshold-1 lets the state
      // change land on the same edge as the increment that reaches it.
      always_comb begin
         state_d = state_q;
         elap_d  = elap_q;
         if (remove[i]) begin
            state_d = IDLE;
            elap_d  = '0;
         end else if (state_q == IDLE) begin
            if (start[i]) begin
               state_d = COOKING;
               elap_d  = '0;
            end
         end else if (tick) begin
            elap_d = (elap_q == SEC_MAX) ? elap_q : elap_q + 1'b1;
            if (state_q == COOKING && elap_q == COOK_LAST) begin
               state_d = DONE;
            end else if (state_q == DONE && elap_q == BURN_LAST) begin
               state_d = BURNT;
            end
         end
      end

      always_comb begin
         done_d  = (state_q == COOKING) && (state_d == DONE);
         burnt_d = (state_q == DONE) && (state_d == BURNT);
      end

      assign slot_state[2*i +: 2]     = state_q;
      assign elapsed[SEC_W*i +: SEC_W] = elap_q;
      assign done_pulse[i]            = done_q;
      assign burnt_pulse[i]           = burnt_q;
   end

endmodule

// File: tb/tb_grill_timer.sv
// Directed bench for grill_timer with CLK_DIV=4, COOK=2, BURN=4, SEC_W=3, 2 slots.
module tb_grill_timer;
   import grill_pkg::*;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] start = '0;
   logic [1:0] remove = '0;
`ifdef GRILL_TIMER_PAUSE_EN
   logic       pause = 1'b0;
`endif
   logic       tick, beat;
   logic [3:0] slot_state;
   logic [5:0] elapsed;
   logic [1:0] done_pulse, burnt_pulse;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc = 0;

   grill_timer #(
      .NUM_SLOTS (2),
      .CLK_DIV   (4),
      .SEC_W     (3),
      .COOK_SECS (2),
      .BURN_SECS (4)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .remove      (remove),
`ifdef GRILL_TIMER_PAUSE_EN
      .pause       (pause),
`endif
      .tick        (tick),
      .beat        (beat),
      .slot_state  (slot_state),
      .elapsed     (elapsed),
      .done_pulse  (done_pulse),
      .burnt_pulse (burnt_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; cycle k = after edge k since release.
   task automatic step(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk);
         cyc++;
         #1;
      end
   endtask

   task automatic check_slots(input string tag, input logic [1:0] s0, input logic [2:0] e0,
                              input logic [1:0] s1, input logic [2:0] e1);
      check({tag, "_s0"}, 32'(slot_state[1:0]), 32'(s0));
      check({tag, "_e0"}, 32'(elapsed[2:0]), 32'(e0));
      check({tag, "_s1"}, 32'(slot_state[3:2]), 32'(s1));
      check({tag, "_e1"}, 32'(elapsed[5:3]), 32'(e1));
   endtask

   task automatic check_pulses(input string tag, input logic [1:0] dp, input logic [1:0] bp);
      check({tag, "_done"}, 32'(done_pulse), 32'(dp));
      check({tag, "_burnt"}, 32'(burnt_pulse), 32'(bp));
   endtask

   initial begin
      // Release reset just after a falling edge so edge 1 is the first active edge.
      @(negedge clk);
      @(negedge clk);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_beat", 32'(beat), 32'd0);
      check_slots("rst", 2'd0, 3'd0, 2'd0, 3'd0);
      check_pulses("rst", 2'b00, 2'b00);
      resetn = 1'b1;
      cyc = 0;

      // Tick cadence over the first 12 cycles; slot 0 started in cycle 1.
      for (int unsigned c = 1; c <= 12; c++) begin
         step(1);
         check("tick_cad", 32'(tick), (c % 4 == 0) ? 32'd1 : 32'd0);
         if (c == 1) start = 2'b01;
         if (c == 2) begin
            start = 2'b00;
            check_slots("start0", 2'd1, 3'd0, 2'd0, 3'd0);
         end
         if (c == 4) check("beat_1st", 32'(beat), 32'd1);
         if (c == 5) check_slots("tick4", 2'd1, 3'd1, 2'd0, 3'd0);
         if (c == 8) check("beat_2nd", 32'(beat), 32'd0);
         if (c == 9) begin
            check_slots("done0", 2'd2, 3'd2, 2'd0, 3'd0);
            check_pulses("done0", 2'b01, 2'b00);
         end
         if (c == 10) begin
            check_pulses("done0_end", 2'b00, 2'b00);
            start = 2'b10;
            remove = 2'b10;
         end
         if (c == 11) begin
            start = 2'b00;
            remove = 2'b00;
            check("st_rm_s1", 32'(slot_state[3:2]), 32'd0);
         end
         if (c == 12) start = 2'b10;
      end

      step(1); // 13: start[1] landed on a tick edge
      start = 2'b00;
      check_slots("start_tick", 2'd2, 3'd3, 2'd1, 3'd0);
      step(4); // 17
      check_slots("burnt0", 2'd3, 3'd4, 2'd1, 3'd1);
      check_pulses("burnt0", 2'b00, 2'b01);
      step(1); // 18
      check_pulses("burnt0_end", 2'b00, 2'b00);
      step(3); // 21
      check_slots("done1", 2'd3, 3'd5, 2'd2, 3'd2);
      check_pulses("done1", 2'b10, 2'b00);
      step(8); // 29
      check_slots("burnt1", 2'd3, 3'd7, 2'd3, 3'd4);
      check_pulses("burnt1", 2'b00, 2'b10);
      step(4); // 33
      check_slots("sat", 2'd3, 3'd7, 2'd3, 3'd5);

      remove = 2'b11;
      step(1); // 34
      remove = 2'b00;
      check_slots("remove_all", 2'd0, 3'd0, 2'd0, 3'd0);
      start = 2'b01;
      step(1); // 35
      start = 2'b00;
      check_slots("restart0", 2'd1, 3'd0, 2'd0, 3'd0);
      step(6); // 41
      check_slots("redone0", 2'd2, 3'd2, 2'd0, 3'd0);
      remove = 2'b01;
      step(1); // 42
      remove = 2'b00;
      step(1); // 43
      check_slots("rm_done", 2'd0, 3'd0, 2'd0, 3'd0);
      check_pulses("rm_done", 2'b00, 2'b00);
      step(1); // 44
      start = 2'b01;
      step(1); // 45
      start = 2'b00;
      check_slots("rm_restart", 2'd1, 3'd0, 2'd0, 3'd0);
      check_pulses("rm_restart", 2'b00, 2'b00);
      step(4); // 49
      check_slots("pre_rst", 2'd1, 3'd1, 2'd0, 3'd0);

      resetn = 1'b0;
      #1;
      check_slots("async_rst", 2'd0, 3'd0, 2'd0, 3'd0);
      check("async_rst_tick", 32'(tick), 32'd0);
      check("async_rst_beat", 32'(beat), 32'd0);
      step(1);
      resetn = 1'b1;
      cyc = 0;
      step(3);
      check("post_rst_t3", 32'(tick), 32'd0);
      step(1);
      check("post_rst_t4", 32'(tick), 32'd1);

`ifdef GRILL_TIMER_PAUSE_EN
      start = 2'b01;
      step(1); // 5
      start = 2'b00;
      check_slots("p_start", 2'd1, 3'd0, 2'd0, 3'd0);
      pause = 1'b1;
      for (int unsigned c = 6; c <= 15; c++) begin
         step(1);
         check("p_tick", 32'(tick), 32'd0);
         check("p_elap", 32'(elapsed[2:0]), 32'd0);
      end
      pause = 1'b0;
      step(2); // 17
      check("p_tick17", 32'(tick), 32'd0);
      step(1); // 18 = 4 + 4 + 10 paused cycles
      check("p_tick18", 32'(tick), 32'd1);
      step(1); // 19
      check_slots("p_resume", 2'd1, 3'd1, 2'd0, 3'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1);
   end

endmodule

// File: doc/grill_timer.md
# grill_timer

Multi-slot cook timer for the grill playfield: a shared prescaler derives a one-second tick from the system clock, and each of NUM_SLOTS independent slots tracks elapsed cook time for one steak. Each slot walks IDLE -> COOKING -> DONE -> BURNT and emits one-cycle pulses at each doneness transition. It replaces the single fixed-period toggle counter. The legacy square wave is kept as the `beat` output, so existing consumers keep working.

## Interface

- NUM_SLOTS, 4, number of independent grill slots (1..16)
- CLK_DIV, 50_000_000, clk cycles per tick (>= 2)
- SEC_W, 6, width of per-slot elapsed-seconds counter
- COOK_SECS, 10, elapsed seconds at which a slot becomes DONE (>= 1)
- BURN_SECS, 20, elapsed seconds at which a slot becomes BURNT (> COOK_SECS, <= 2^SEC_W-1)
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  NUM_SLOTS  per-slot start request, sampled each cycle
- remove  in  NUM_SLOTS  per-slot remove request, sampled each cycle
- tick  out  1  registered one-cycle pulse, once per CLK_DIV cycles
- beat  out  1  toggles on every tick (50% square wave, period 2*CLK_DIV)
- slot_state  out  2*NUM_SLOTS  per-slot state, slot i at [2i+1:2i]; 0 IDLE, 1 COOKING, 2 DONE, 3 BURNT
- elapsed  out  SEC_W*NUM_SLOTS  per-slot elapsed seconds, slot i at [SEC_W*i +: SEC_W]
- done_pulse  out  NUM_SLOTS  one cycle high on the COOKING->DONE transition
- burnt_pulse  out  NUM_SLOTS  one cycle high on the DONE->BURNT transition

## Operation

- Reset values: all outputs 0; all slots IDLE; prescaler count 0.
- Prescaler: free-running, counts 0..CLK_DIV-1 and wraps. Start and remove never restart it, so a slot's first second is partial (0..CLK_DIV-1 cycles).
- Per slot, evaluated each cycle, in priority order:
  - remove=1: state IDLE, elapsed 0 (any state). Remove wins over a simultaneous start.
  - start=1 in IDLE: state COOKING, elapsed 0. A tick in the same cycle is not counted.
  - start in COOKING, DONE or BURNT: ignored.
  - tick in COOKING, DONE or BURNT: elapsed+1, saturating at 2^SEC_W-1.
  - Transitions occur in the same edge as the increment that reaches the threshold. Elapsed+1 == COOK_SECS in COOKING goes to DONE; elapsed+1 == BURN_SECS in DONE goes to BURNT.
- BURNT is terminal until remove. Elapsed keeps counting there until it saturates.
- Pulse outputs are registered and coincide with the first cycle the new state is visible.
- Slots are fully independent; any combination of simultaneous events across slots is legal.

## Timing

- tick is high in the cycle after the prescaler holds CLK_DIV-1. The first tick is high at cycle CLK_DIV after reset deassertion; ticks then repeat every CLK_DIV cycles.
- beat toggles on the edge that raises tick.
- start/remove to slot_state/elapsed latency: 1 cycle.
- tick to elapsed/slot_state/pulse update: 1 cycle. The update lands the edge after tick is seen high.
- Asserting resetn low mid-cook clears everything immediately (asynchronous). The first tick after release again needs CLK_DIV cycles.

## Configuration

- GRILL_TIMER_PAUSE_EN defined: adds input `pause` (1 bit, after remove).
  - While pause=1, the prescaler holds its count, tick and beat do not advance, and no slot's elapsed changes.
  - start and remove still act normally.
  - Tick resumes exactly where counting stopped.
- Undefined: no pause port; the prescaler always runs.

## Structure

- Shared package grill_pkg:
  - slot_state_t enum (IDLE=2'd0, COOKING=2'd1, DONE=2'd2, BURNT=2'd3)
  - SLOT_STATE_W=2 localparam
  - Reused by the scoring and display blocks.
- Sub-module tick_prescaler (parameter CLK_DIV; ports clk, resetn, optional pause, tick, beat).
- Slot logic is a generate loop of NUM_SLOTS identical FSM+counter instances in the top level.

## Test plan

Bench overrides CLK_DIV=4, COOK_SECS=2, BURN_SECS=4, SEC_W=3, NUM_SLOTS=2.

- Reset release, no input: tick high at cycles 4, 8, 12; beat reads 1 after the first tick and 0 after the second; all slots stay IDLE.
- start[0] pulse at cycle 1: slot 0 COOKING at cycle 2; elapsed 1 after the tick at 4; DONE with done_pulse[0] after the tick at 8; BURNT with burnt_pulse[0] after the tick at 16; elapsed saturates at 7 and never wraps.
- start[1] and remove[1] in the same cycle from IDLE: slot 1 stays IDLE. start[1] coincident with a tick: elapsed stays 0 until the next tick.
- remove[0] while DONE, then start[0] two cycles later: IDLE with elapsed 0, then COOKING with elapsed 0; no spurious pulses.
- resetn low for 1 cycle while slot 0 is COOKING with elapsed 1: all outputs 0 immediately; the next tick arrives 4 cycles after release.
- With GRILL_TIMER_PAUSE_EN, pause held for 10 cycles mid-cook: no tick and no elapsed change during the pause; the tick spacing across the pause equals 4 plus the paused cycles.
